// File: rtl/voice_allocator.sv
// voice_allocator: assigns note events to free, released or stolen voices. Ports: clk/rst_n, ev_* handshake, voice_idle in, voice_gate/note/load and steal out.
module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int NOTE_BITS     = 7,
  parameter int AGE_BITS      = 8,
  parameter int RETRIG_CYCLES = 2048
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [NOTE_BITS-1:0]            ev_note,
  input  logic [NUM_VOICES-1:0]           voice_idle,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic [NUM_VOICES-1:0]           voice_load,
  output logic                            steal
);
  localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int CW = $clog2(RETRIG_CYCLES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
  typedef enum logic [2:0] {WAIT, SCAN, ACT, APPLY, RETRIG} state_t;
  typedef enum logic [1:0] {M_NONE, M_OFF, M_ASSIGN, M_RETRIG} mode_t;
  state_t state, next;
  mode_t mode;
  logic [IW-1:0] idx, tgt, match_idx, free_idx, rel_idx, old_idx;
  logic match_f, free_f, rel_f, old_f, on_q, steal_q, accept, do_load;
  logic [NOTE_BITS-1:0] note_q;
  logic [NOTE_BITS-1:0] notes [NUM_VOICES];
  logic [AGE_BITS-1:0] ages [NUM_VOICES];
  logic [AGE_BITS-1:0] rel_age, old_age;
  logic [CW-1:0] cnt;
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_note
    assign voice_note[i*NOTE_BITS +: NOTE_BITS] = notes[i];
  end
  assign accept = state == WAIT && ev_valid && ev_ready;
  // a voice takes its new note either straight from APPLY or at the end of the retrigger gap
  assign do_load = (state == APPLY && mode == M_ASSIGN) || (state == RETRIG && cnt == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      WAIT:    next = accept ? SCAN : WAIT;
      SCAN:    next = idx == LAST ? ACT : SCAN;
      ACT:     next = APPLY;
      APPLY:   next = mode == M_RETRIG ? RETRIG : WAIT;
      RETRIG:  next = cnt == '0 ? WAIT : RETRIG;
      default: next = WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_ready   <= 1'b0;
      voice_gate <= '0;
      voice_load <= '0;
      steal      <= 1'b0;
      mode       <= M_NONE;
      {idx, tgt, match_idx, free_idx, rel_idx, old_idx} <= '0;
      {match_f, free_f, rel_f, old_f, on_q, steal_q} <= '0;
      note_q     <= '0;
      rel_age    <= '0;
      old_age    <= '0;
      cnt        <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        notes[i] <= '0;
        ages[i]  <= '0;
      end
    end else begin
      ev_ready   <= next == WAIT;
      voice_load <= '0;
      steal      <= 1'b0;
      case (state)
        WAIT: if (accept) begin
          on_q   <= ev_on;
          note_q <= ev_note;
          idx    <= '0;
          {match_f, free_f, rel_f, old_f} <= '0;
        end
        SCAN: begin
          if (voice_gate[idx] && notes[idx] == note_q && !match_f) begin
            match_f   <= 1'b1;
            match_idx <= idx;
          end
          if (!voice_gate[idx] && voice_idle[idx] && !free_f) begin
            free_f   <= 1'b1;
            free_idx <= idx;
          end
          // strict compare keeps the lowest index on age ties
          if (!voice_gate[idx] && !voice_idle[idx] && (!rel_f || ages[idx] > rel_age)) begin
            rel_f   <= 1'b1;
            rel_idx <= idx;
            rel_age <= ages[idx];
          end
          if (voice_gate[idx] && (!old_f || ages[idx] > old_age)) begin
            old_f   <= 1'b1;
            old_idx <= idx;
            old_age <= ages[idx];
          end
          idx <= idx + 1'b1;
        end
        ACT: begin
          steal_q <= 1'b0;
          if (!on_q) mode <= M_OFF;
          else if (match_f) begin
            mode <= M_RETRIG;
            tgt  <= match_idx;
          end else if (free_f || rel_f) begin
            mode <= M_ASSIGN;
            tgt  <= free_f ? free_idx : rel_idx;
          end else begin
            mode    <= M_RETRIG;
            tgt     <= old_idx;
            steal_q <= 1'b1;
          end
        end
        APPLY: begin
          if (mode == M_OFF)
            for (int i = 0; i < NUM_VOICES; i++)
              if (voice_gate[i] && notes[i] == note_q) voice_gate[i] <= 1'b0;
          if (mode == M_RETRIG) begin
            voice_gate[tgt] <= 1'b0;
            cnt             <= CW'(RETRIG_CYCLES - 1);
          end
        end
        RETRIG: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (do_load) begin
        notes[tgt]      <= note_q;
        voice_gate[tgt] <= 1'b1;
        voice_load[tgt] <= 1'b1;
        steal           <= steal_q && state == RETRIG;
        for (int i = 0; i < NUM_VOICES; i++)
          ages[i] <= IW'(i) == tgt ? '0 : (&ages[i] ? ages[i] : ages[i] + 1'b1);
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench for voice_allocator with directed note events.
module tb_voice_allocator;
  logic clk = 0, rst_n = 0, ev_valid = 0, ev_on = 0, ev_ready, steal;
  logic [6:0] ev_note = '0;
  logic [3:0] voice_idle = 4'hF, voice_gate, voice_load;
  logic [27:0] voice_note;
  typedef struct {int v; int note; bit stl; int cyc;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, fails = 0;

  voice_allocator dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .voice_idle(voice_idle), .voice_gate(voice_gate),
    .voice_note(voice_note), .voice_load(voice_load), .steal(steal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (steal && voice_load == 0) check("steal_without_load", 1, 0);
    if (voice_load != 0) begin
      if (q.size() == 0) check("unexpected_load", int'(voice_load), 0);
      else begin
        e = q.pop_front();
        check("load_voice", int'(voice_load), 1 << e.v);
        check("load_note", int'(voice_note[e.v*7 +: 7]), e.note);
        check("load_gate", int'(voice_gate[e.v]), 1);
        check("load_steal", int'(steal), int'(e.stl));
        check("load_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ev_ready), 0);
    check("rst_gate", int'(voice_gate), 0);
    check("rst_note", int'(voice_note), 0);
    rst_n = 1;
    @(negedge clk);
    check("ready_after_rst", int'(ev_ready), 1);
  endtask

  task automatic send(input bit on, input int note, output int acc);
    int t = 0;
    @(negedge clk);
    ev_on = on; ev_note = 7'(note); ev_valid = 1;
    while (!ev_ready && t < 100) begin @(negedge clk); t++; end
    if (!ev_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    acc = cyc; ev_valid = 0;
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!ev_ready && t < 5000) begin @(negedge clk); t++; end
    check("ready_return", int'(ev_ready), 1);
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
  endtask

  task automatic on_expect(input int note, input int v);
    int acc;
    send(1, note, acc);
    q.push_back('{v, note, 1'b0, acc + 6});
    wait_ready();
  endtask

  task automatic retrig_expect(input int note, input int v, input bit stl);
    int acc, t = 0, low = 0;
    send(1, note, acc);
    q.push_back('{v, note, stl, acc + 6 + 2048});
    while (voice_gate[v] && t < 100) begin @(negedge clk); t++; end
    while (!voice_gate[v] && low < 3000) begin @(negedge clk); low++; end
    check("retrig_low_cycles", low, 2048);
    wait_ready();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, n, last, t, bad;
    do_reset();
    on_expect(60, 0);
    on_expect(62, 1);
    on_expect(64, 2);
    on_expect(67, 3);
    check("four_gated", int'(voice_gate), 4'hF);
    retrig_expect(72, 0, 1);
    check("steal_gates", int'(voice_gate), 4'hF);
    check("steal_notes", int'(voice_note), int'({7'd67, 7'd64, 7'd62, 7'd72}));

    do_reset();
    on_expect(60, 0);
    on_expect(62, 1);
    on_expect(64, 2);
    on_expect(67, 3);
    send(0, 62, acc);
    wait_ready();
    check("noteoff_gate", int'(voice_gate), 4'b1101);
    voice_idle = 4'b1101;
    on_expect(65, 1);
    check("released_reuse", int'(voice_gate), 4'hF);
    retrig_expect(64, 2, 0);
    check("retrig_gates", int'(voice_gate), 4'hF);
    check("retrig_notes", int'(voice_note), int'({7'd67, 7'd64, 7'd65, 7'd60}));

    @(negedge clk);
    ev_on = 0; ev_note = 100; ev_valid = 1;
    n = 0; last = 0; t = 0;
    while (n < 3 && t < 200) begin
      if (ev_ready) begin
        @(negedge clk); t++;
        if (n > 0) check("accept_gap", int'((cyc - last) >= 6), 1);
        last = cyc; n++; ev_note = ev_note + 1;
        if (n == 3) ev_valid = 0;
        check("ready_low_after_accept", int'(ev_ready), 0);
      end else begin
        @(negedge clk); t++;
      end
    end
    ev_valid = 0;
    check("accept_count", n, 3);
    wait_ready();
    check("offs_no_effect", int'(voice_gate), 4'hF);

    send(1, 72, acc);
    repeat (100) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async_gate", int'(voice_gate), 0);
    check("async_note", int'(voice_note), 0);
    check("async_ready", int'(ev_ready), 0);
    @(negedge clk);
    rst_n = 1;
    bad = 0;
    repeat (2200) begin
      @(negedge clk);
      if (voice_gate != 0 || voice_load != 0) bad++;
    end
    check("no_residual_gate", bad, 0);
    on_expect(50, 0);
    check("post_reset_gate", int'(voice_gate), 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
